// File: rtl/icebus_motor_responder_if.sv
// Byte-engine handshake between the motor responder and the shared uart_rx/uart_tx pair.
interface icebus_motor_responder_if;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [7:0] tx_byte;
  logic       tx_start;
  logic       tx_busy;

  modport master (output rx_byte, rx_valid, tx_busy, input tx_byte, tx_start);
  modport slave  (input rx_byte, rx_valid, tx_busy, output tx_byte, tx_start);
endinterface

// File: rtl/icebus_motor_responder.sv
// icebus motor-board responder: hunts request frames, validates id/CRC16, latches
// controller parameters and answers status requests with a 28-byte status frame.
module icebus_motor_responder #(
  parameter int unsigned CLK_FREQ_HZ           = 50_000_000,
  parameter int unsigned RX_TIMEOUT_CYCLES     = 50_000,
  parameter int unsigned RESPONSE_DELAY_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  icebus_motor_responder_if.slave bus,
  input  logic [7:0]              i_my_id,
  input  logic signed [23:0]      i_encoder0_position,
  input  logic signed [23:0]      i_encoder1_position,
  input  logic signed [23:0]      i_duty,
  input  logic signed [23:0]      i_displacement,
  input  logic signed [15:0]      i_current,
  output logic [7:0]              o_control_mode,
  output logic signed [15:0]      o_Kp,
  output logic signed [15:0]      o_Ki,
  output logic signed [15:0]      o_Kd,
  output logic signed [23:0]      o_PWMLimit,
  output logic signed [23:0]      o_IntegralLimit,
  output logic signed [23:0]      o_deadband,
  output logic signed [23:0]      o_setpoint,
  output logic signed [15:0]      o_current_limit,
  output logic [23:0]             o_neopxl_color,
  output logic                    o_config_update,
  output logic                    o_setpoint_update,
  output logic [15:0]             o_crc_error_count
);
  localparam logic [31:0] MAGIC_REQ = 32'h1CE1_CEBB;
  localparam logic [31:0] MAGIC_SP  = 32'hD0D0_D0D0;
  localparam logic [31:0] MAGIC_CM  = 32'hBAAD_A555;
  localparam logic [31:0] MAGIC_RSP = 32'h1CEB_00DA;
  localparam int TO_W = $clog2(RX_TIMEOUT_CYCLES + 1);
  localparam int DL_W = $clog2(RESPONSE_DELAY_CYCLES + 1);

  typedef enum logic [2:0] {S_HUNT, S_COLLECT, S_CHECK, S_DELAY, S_SEND} state_t;
  typedef enum logic [1:0] {K_REQ, K_SP, K_CM} kind_t;
  typedef enum logic [1:0] {PH_START, PH_RISE, PH_FALL} phase_t;

  // CRC-16/CCITT (poly 0x1021), data MSB first -- same result as nextCRC16_D8.
  function automatic logic [15:0] crc16_d8(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--)
      r = {r[14:0], 1'b0} ^ (((r[15] ^ d[i]) != 1'b0) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  state_t           r_state, w_state_nxt;
  kind_t            r_kind, w_hit_kind;
  phase_t           r_ph;
  logic [31:0]      r_magic, w_magic_sh;
  logic [4:0]       r_len, r_idx, r_n, w_hit_len;
  logic [TO_W-1:0]  r_idle;
  logic [DL_W-1:0]  r_dly;
  logic [15:0]      r_crc, r_tcrc;
  logic [7:0]       r_pay [24];
  logic [25:0][7:0] r_snap;
  logic             w_hit, w_id_ok, w_crc_ok;
  logic             w_cfg_we, w_sp_we, w_snap_we, w_crc_bad, w_tx_start;
  logic [7:0]       w_tx_byte;

  logic [7:0]         r_mode;
  logic signed [15:0] r_kp, r_ki, r_kd, r_cl;
  logic signed [23:0] r_pwm, r_il, r_db, r_sp;
  logic [23:0]        r_np;
  logic               r_cfg_upd, r_sp_upd;
  logic [15:0]        r_err;

  assign w_magic_sh = {r_magic[23:0], bus.rx_byte};
  assign w_id_ok    = (r_pay[0] == i_my_id);
  assign w_crc_ok   = ({r_pay[r_len - 5'd2], r_pay[r_len - 5'd1]} == r_crc);

  always_comb begin
    w_hit      = 1'b1;
    w_hit_kind = K_REQ;
    w_hit_len  = 5'd3;
    case (w_magic_sh)
      MAGIC_REQ: ;
      MAGIC_SP:  begin w_hit_kind = K_SP; w_hit_len = 5'd9;  end
      MAGIC_CM:  begin w_hit_kind = K_CM; w_hit_len = 5'd24; end
      default:   w_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_HUNT;
    else       r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HUNT:    if (bus.rx_valid && w_hit) w_state_nxt = S_COLLECT;
      S_COLLECT: begin
        if (bus.rx_valid) begin
          if (r_idx == r_len - 5'd1) w_state_nxt = S_CHECK;
        end else if (r_idle == TO_W'(RX_TIMEOUT_CYCLES - 1)) w_state_nxt = S_HUNT;
      end
      S_CHECK:   w_state_nxt = w_snap_we ? S_DELAY : S_HUNT;
      S_DELAY:   if (r_dly == DL_W'(RESPONSE_DELAY_CYCLES - 1)) w_state_nxt = S_SEND;
      S_SEND:    if (r_ph == PH_FALL && !bus.tx_busy && r_n == 5'd27) w_state_nxt = S_HUNT;
      default:   w_state_nxt = S_HUNT;
    endcase
  end

  always_comb begin
    w_cfg_we   = 1'b0;
    w_sp_we    = 1'b0;
    w_snap_we  = 1'b0;
    w_crc_bad  = 1'b0;
    w_tx_start = 1'b0;
    w_tx_byte  = 8'h00;
    case (r_state)
      S_CHECK: if (w_id_ok) begin
        if (!w_crc_ok) w_crc_bad = 1'b1;
        else case (r_kind)
          K_CM:    w_cfg_we  = 1'b1;
          K_SP:    w_sp_we   = 1'b1;
          default: w_snap_we = 1'b1;
        endcase
      end
      S_SEND: begin
        w_tx_start = (r_ph == PH_START) && !bus.tx_busy;
        if (r_n < 5'd26)       w_tx_byte = r_snap[5'd25 - r_n];
        else if (r_n == 5'd26) w_tx_byte = r_tcrc[15:8];
        else                   w_tx_byte = r_tcrc[7:0];
      end
      default: ;
    endcase
  end

  assign bus.tx_start = w_tx_start;
  assign bus.tx_byte  = w_tx_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_magic <= '0;
      r_kind  <= K_REQ;
      r_len   <= '0;
      r_idx   <= '0;
      r_idle  <= '0;
      r_crc   <= 16'hFFFF;
      r_dly   <= '0;
      r_n     <= '0;
      r_ph    <= PH_START;
      r_tcrc  <= 16'hFFFF;
    end else begin
      case (r_state)
        S_HUNT: if (bus.rx_valid) begin
          // Cleared on a hit so payload bytes can never re-trigger a frame.
          if (w_hit) begin
            r_magic <= '0;
            r_kind  <= w_hit_kind;
            r_len   <= w_hit_len;
            r_idx   <= '0;
            r_idle  <= '0;
            r_crc   <= 16'hFFFF;
          end else r_magic <= w_magic_sh;
        end
        S_COLLECT: begin
          if (bus.rx_valid) begin
            r_idx  <= r_idx + 5'd1;
            r_idle <= '0;
            if (r_idx < r_len - 5'd2) r_crc <= crc16_d8(r_crc, bus.rx_byte);
          end else r_idle <= r_idle + TO_W'(1);
        end
        S_CHECK: begin
          r_dly  <= '0;
          r_n    <= '0;
          r_ph   <= PH_START;
          r_tcrc <= 16'hFFFF;
        end
        S_DELAY: r_dly <= r_dly + DL_W'(1);
        S_SEND: case (r_ph)
          PH_START: if (!bus.tx_busy) begin
            r_ph <= PH_RISE;
            if (r_n >= 5'd4 && r_n <= 5'd25) r_tcrc <= crc16_d8(r_tcrc, w_tx_byte);
          end
          PH_RISE: if (bus.tx_busy) r_ph <= PH_FALL;
          default: if (!bus.tx_busy) begin
            r_ph <= PH_START;
            r_n  <= r_n + 5'd1;
            if (r_n == 5'd27) r_magic <= '0;
          end
        endcase
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_COLLECT && bus.rx_valid) r_pay[r_idx] <= bus.rx_byte;
    if (w_snap_we)
      r_snap <= {MAGIC_RSP, i_my_id, r_mode, i_encoder0_position, i_encoder1_position,
                 r_sp, i_duty, i_displacement, i_current, r_np};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode <= '0; r_kp <= '0; r_ki <= '0; r_kd <= '0; r_cl <= '0;
      r_pwm  <= '0; r_il <= '0; r_db <= '0; r_sp <= '0; r_np <= '0;
      r_cfg_upd <= 1'b0; r_sp_upd <= 1'b0; r_err <= '0;
    end else begin
      r_cfg_upd <= w_cfg_we;
      r_sp_upd  <= w_cfg_we | w_sp_we;
      if (w_cfg_we) begin
        r_mode <= r_pay[1];
        r_kp   <= {r_pay[2], r_pay[3]};
        r_ki   <= {r_pay[4], r_pay[5]};
        r_kd   <= {r_pay[6], r_pay[7]};
        r_pwm  <= {r_pay[8], r_pay[9], r_pay[10]};
        r_il   <= {r_pay[11], r_pay[12], r_pay[13]};
        r_db   <= {r_pay[14], r_pay[15], r_pay[16]};
        r_sp   <= {r_pay[17], r_pay[18], r_pay[19]};
        r_cl   <= {r_pay[20], r_pay[21]};
      end
      if (w_sp_we) begin
        r_sp <= {r_pay[1], r_pay[2], r_pay[3]};
        r_np <= {r_pay[4], r_pay[5], r_pay[6]};
      end
      if (w_crc_bad && r_err != 16'hFFFF) r_err <= r_err + 16'd1;
    end
  end

  assign o_control_mode    = r_mode;
  assign o_Kp              = r_kp;
  assign o_Ki              = r_ki;
  assign o_Kd              = r_kd;
  assign o_PWMLimit        = r_pwm;
  assign o_IntegralLimit   = r_il;
  assign o_deadband        = r_db;
  assign o_setpoint        = r_sp;
  assign o_current_limit   = r_cl;
  assign o_neopxl_color    = r_np;
  assign o_config_update   = r_cfg_upd;
  assign o_setpoint_update = r_sp_upd;
  assign o_crc_error_count = r_err;
endmodule

// File: tb/tb_icebus_motor_responder.sv
// Randomized frame-level bench for icebus_motor_responder with a field-level reference model.
module tb_icebus_motor_responder;
  localparam int TO       = 50_000;
  localparam int DLY      = 500;
  localparam int BUSY_CYC = 8;
  localparam logic [31:0] MG_REQ = 32'h1CE1_CEBB;
  localparam logic [31:0] MG_SP  = 32'hD0D0_D0D0;
  localparam logic [31:0] MG_CM  = 32'hBAAD_A555;
  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  icebus_motor_responder_if bus();
  logic [7:0]  my_id;
  logic [23:0] enc0, enc1, duty, disp;
  logic [15:0] cur;
  logic [7:0]  mode;
  logic [15:0] kp, ki, kd, cl, errc;
  logic [23:0] pwm, il, db, sp, np;
  logic        cfg_up, sp_up;

  icebus_motor_responder #(.RX_TIMEOUT_CYCLES(TO), .RESPONSE_DELAY_CYCLES(DLY)) dut (
    .clk(clk), .reset(reset), .bus(bus), .i_my_id(my_id),
    .i_encoder0_position(enc0), .i_encoder1_position(enc1), .i_duty(duty),
    .i_displacement(disp), .i_current(cur),
    .o_control_mode(mode), .o_Kp(kp), .o_Ki(ki), .o_Kd(kd), .o_PWMLimit(pwm),
    .o_IntegralLimit(il), .o_deadband(db), .o_setpoint(sp), .o_current_limit(cl),
    .o_neopxl_color(np), .o_config_update(cfg_up), .o_setpoint_update(sp_up),
    .o_crc_error_count(errc));

  int nchk = 0, nerr = 0, cyc = 0, last_rx = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // uart_tx stand-in: latches tx_byte on tx_start, then busy for BUSY_CYC cycles.
  bq_t cap;
  int  cap_cyc [$];
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        cap.push_back(bus.tx_byte);
        cap_cyc.push_back(cyc);
        @(posedge clk); #1 bus.tx_busy = 1'b1;
        repeat (BUSY_CYC) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  int sp_pulses = 0, cfg_pulses = 0, sp_last = 0;
  always @(negedge clk) begin
    if (sp_up === 1'b1) begin sp_pulses <= sp_pulses + 1; sp_last <= cyc; end
    if (cfg_up === 1'b1) cfg_pulses <= cfg_pulses + 1;
  end

  // Reference model state and the field values of the next frame to send.
  logic [7:0]  m_mode, f_mode;
  logic [15:0] m_kp, m_ki, m_kd, m_cl, m_err, f_kp, f_ki, f_kd, f_cl;
  logic [23:0] m_pwm, m_il, m_db, m_sp, m_np, f_pwm, f_il, f_db, f_sp, f_np;

  function automatic logic [15:0] ref_crc(input bq_t q, input int from, input int to);
    logic [15:0] c = 16'hFFFF;
    for (int i = from; i <= to; i++) begin
      c = c ^ {q[i], 8'h00};
      for (int b = 0; b < 8; b++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  function automatic bq_t mk_frame(input logic [31:0] mg, input bq_t pl, input bit bad);
    bq_t f;
    logic [15:0] c;
    c = ref_crc(pl, 0, pl.size() - 1);
    f = {mg[31:24], mg[23:16], mg[15:8], mg[7:0]};
    f = {f, pl, c[15:8], c[7:0] ^ (bad ? 8'h01 : 8'h00)};
    return f;
  endfunction

  function automatic bq_t mk_rsp();
    bq_t r;
    logic [15:0] c;
    r = {8'h1C, 8'hEB, 8'h00, 8'hDA, my_id, m_mode,
         enc0[23:16], enc0[15:8], enc0[7:0], enc1[23:16], enc1[15:8], enc1[7:0],
         m_sp[23:16], m_sp[15:8], m_sp[7:0], duty[23:16], duty[15:8], duty[7:0],
         disp[23:16], disp[15:8], disp[7:0], cur[15:8], cur[7:0],
         m_np[23:16], m_np[15:8], m_np[7:0]};
    c = ref_crc(r, 4, 25);
    r = {r, c[15:8], c[7:0]};
    return r;
  endfunction

  task automatic send(input bq_t f);
    foreach (f[i]) begin
      @(posedge clk); #1 bus.rx_byte = f[i]; bus.rx_valid = 1'b1; last_rx = cyc;
      @(posedge clk); #1 bus.rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic rnd_inputs();
    enc0 = 24'($urandom); enc1 = 24'($urandom); duty = 24'($urandom);
    disp = 24'($urandom); cur = 16'($urandom);
  endtask

  task automatic rnd_fields();
    f_mode = 8'($urandom); f_kp = 16'($urandom); f_ki = 16'($urandom); f_kd = 16'($urandom);
    f_cl = 16'($urandom); f_pwm = 24'($urandom); f_il = 24'($urandom); f_db = 24'($urandom);
    f_sp = 24'($urandom); f_np = 24'($urandom);
  endtask

  task automatic model_reset();
    m_mode = 0; m_kp = 0; m_ki = 0; m_kd = 0; m_cl = 0; m_err = 0;
    m_pwm = 0; m_il = 0; m_db = 0; m_sp = 0; m_np = 0;
  endtask

  task automatic check_outputs();
    chk("control_mode", mode, m_mode); chk("Kp", kp, m_kp); chk("Ki", ki, m_ki);
    chk("Kd", kd, m_kd); chk("PWMLimit", pwm, m_pwm); chk("IntegralLimit", il, m_il);
    chk("deadband", db, m_db); chk("setpoint", sp, m_sp); chk("current_limit", cl, m_cl);
    chk("neopxl_color", np, m_np); chk("crc_error_count", errc, m_err);
  endtask

  // kind: 0 status request, 1 setpoint, 2 control mode. dup resends the frame while the
  // response is pending; that copy must be ignored.
  task automatic do_frame(input int kind, input logic [7:0] id, input bit bad, input bit dup);
    bq_t pl, f, exp;
    logic [31:0] mg;
    int sp0, cf0, base, l, k;
    bit ok;
    sp0 = sp_pulses; cf0 = cfg_pulses; base = cap.size();
    ok = (id == my_id) && !bad;
    case (kind)
      0: begin mg = MG_REQ; pl = {id}; end
      1: begin mg = MG_SP;
        pl = {id, f_sp[23:16], f_sp[15:8], f_sp[7:0], f_np[23:16], f_np[15:8], f_np[7:0]}; end
      default: begin mg = MG_CM;
        pl = {id, f_mode, f_kp[15:8], f_kp[7:0], f_ki[15:8], f_ki[7:0], f_kd[15:8], f_kd[7:0],
              f_pwm[23:16], f_pwm[15:8], f_pwm[7:0], f_il[23:16], f_il[15:8], f_il[7:0],
              f_db[23:16], f_db[15:8], f_db[7:0], f_sp[23:16], f_sp[15:8], f_sp[7:0],
              f_cl[15:8], f_cl[7:0]}; end
    endcase
    f = mk_frame(mg, pl, bad);
    if (ok && kind == 0) exp = mk_rsp();
    send(f);
    l = last_rx;
    if (dup) send(f);
    if (id == my_id && bad && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    if (ok && kind == 2) begin
      m_mode = f_mode; m_kp = f_kp; m_ki = f_ki; m_kd = f_kd; m_cl = f_cl;
      m_pwm = f_pwm; m_il = f_il; m_db = f_db; m_sp = f_sp;
    end
    if (ok && kind == 1) begin m_sp = f_sp; m_np = f_np; end
    if (ok && kind == 0) begin
      k = 0;
      while (cap.size() <= base && k < DLY + 100) begin @(negedge clk); k++; end
      rnd_inputs();
      while (cap.size() < base + 28 && k < DLY + 800) begin @(negedge clk); k++; end
      repeat (dup ? DLY + 60 : 30) @(negedge clk);
      chk("rsp_len", cap.size() - base, 28);
      for (int i = 0; i < 28 && base + i < cap.size(); i++) chk($sformatf("rsp_byte%0d", i), cap[base + i], exp[i]);
      if (cap.size() > base) chk("rsp_latency", cap_cyc[base] - l, DLY + 2);
    end else begin
      repeat (kind == 0 ? DLY + 40 : 8) @(negedge clk);
      chk("no_rsp", cap.size() - base, 0);
    end
    repeat (BUSY_CYC + 4) @(negedge clk);
    chk("sp_update_pulses", sp_pulses - sp0, ok && kind != 0);
    chk("cfg_update_pulses", cfg_pulses - cf0, ok && kind == 2);
    if (ok && kind != 0) chk("update_latency", sp_last - l, 2);
    check_outputs();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t g;
    int base, k;
    bus.rx_byte = 8'h00; bus.rx_valid = 1'b0; my_id = 8'h05;
    rnd_inputs(); model_reset(); rnd_fields();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_outputs();
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_cfg_update", cfg_up, 0);
    chk("rst_sp_update", sp_up, 0);

    enc0 = 24'h123456; cur = 16'hFF38;
    do_frame(0, 8'h05, 0, 0);
    f_sp = 24'hFFFC18; f_np = 24'h00FF00;
    do_frame(1, 8'h05, 0, 0);
    rnd_fields(); f_mode = 8'h03; f_kp = 16'h0100; f_pwm = 24'h0003E8;
    do_frame(2, 8'h05, 0, 0);
    do_frame(0, 8'h05, 0, 0);
    f_sp = 24'hFFFC18; f_np = 24'h00FF00;
    do_frame(1, 8'h05, 1, 0);
    do_frame(1, 8'h06, 1, 0);
    do_frame(0, 8'h06, 0, 0);
    do_frame(0, 8'h05, 1, 0);
    f_sp = 24'hD0D0D0; f_np = 24'hD0D0D0;
    do_frame(1, 8'h05, 0, 0);
    do_frame(0, 8'h05, 0, 1);

    // truncated control-mode frame, then silence past the timeout
    send({8'hBA, 8'hAD, 8'hA5, 8'h55, 8'h05, 8'h03, 8'h01, 8'h00, 8'h02, 8'h00});
    repeat (TO + 10) @(posedge clk);
    do_frame(0, 8'h05, 0, 0);

    // reset while the 10th response byte is on the wire
    base = cap.size();
    send(mk_frame(MG_REQ, {my_id}, 0));
    k = 0;
    while (cap.size() < base + 10 && k < DLY + 400) begin @(negedge clk); k++; end
    @(posedge clk); #2 reset = 1'b1;
    model_reset();
    @(negedge clk);
    chk("rst_mid_tx_start", bus.tx_start, 0);
    check_outputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_mid_bytes", cap.size() - base, 10);
    do_frame(0, 8'h05, 0, 0);

    for (int it = 0; it < 8; it++) begin
      int kind;
      kind = $urandom_range(0, 2);
      rnd_fields(); rnd_inputs();
      g = {};
      repeat ($urandom_range(0, 3)) g.push_back(8'($urandom_range(0, 15)));
      send(g);
      do_frame(kind, ($urandom_range(0, 3) == 0) ? 8'h06 : my_id, $urandom_range(0, 3) == 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
